// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sequential ALU with single-cycle, iterative shift and shift-add multiply operations
//
// Purpose: accepts one operation per handshake. Logic and add/subtract operations
//          complete in one cycle. Shifts move one bit per cycle. MUL is an unsigned
//          shift-add multiplier that takes WIDTH cycles. The result is held until
//          the consumer accepts it.
// Ports:
//    clk, rst_n          clock, asynchronous active-low reset
//    in_valid/in_ready   request handshake (in_ready only while idle)
//    A, B, opcode        operands and operation select, captured on acceptance
//    out_valid/out_ready result handshake (out_valid only while a result is held)
//    Out, Flag, err      result, {N,Z,C,V}, undefined-opcode indication
module ula_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic [3:0]       Flag,
   output logic             err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [4:0]       op_r;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [SHW-1:0]   cnt;

   logic [SHW-1:0]   n;
   logic             in_shift;
   logic             in_mul;
   logic             busy_mul;

   assign n         = B[SHW-1:0];
   assign in_shift  = (opcode[4:2] == 3'b010) && (opcode[1:0] != 2'b11);
   assign in_mul    = (opcode == 5'b01100);
   assign busy_mul  = (op_r == 5'b01100);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // One shift step: returns {bit shifted out, shifted value}.
   // k = 00 LSL, 01 ASR, 10 LSR.
   function automatic logic [WIDTH:0] shstep(input logic [1:0] k, input logic [WIDTH-1:0] d);
      case (k)
         2'b00:   shstep = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
         2'b01:   shstep = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
         default: shstep = {d[0], 1'b0, d[WIDTH-1:1]};
      endcase
   endfunction

   // Single-cycle datapath. Every add/subtract is A + addb + cin, so one adder
   // gives carry (no-borrow for subtracts) and overflow for all of them.
   logic [WIDTH-1:0] addb;
   logic [WIDTH-1:0] lres;
   logic [WIDTH-1:0] sres;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic             arith;
   logic             uerr;
   logic             sc;
   logic             sv;

   always_comb begin
      addb  = '0;
      cin   = 1'b0;
      arith = 1'b0;
      lres  = '0;
      uerr  = 1'b0;
      case (opcode)
         5'b00000: begin addb = B;  arith = 1'b1; end
         5'b00001: begin addb = B;  cin = 1'b1; arith = 1'b1; end
         5'b00011: begin addb = '0; cin = 1'b1; arith = 1'b1; end
         5'b00100: begin addb = ~B; arith = 1'b1; end
         5'b00101: begin addb = ~B; cin = 1'b1; arith = 1'b1; end
         5'b00110: begin addb = '1; arith = 1'b1; end
         5'b10000: lres = '0;
         5'b10001: lres = A & B;
         5'b10010: lres = ~A & B;
         5'b10011: lres = B;
         5'b10100: lres = A & ~B;
         5'b10101: lres = A;
         5'b10110: lres = A ^ B;
         5'b10111: lres = A | B;
         5'b11000: lres = ~(A | B);
         5'b11001: lres = ~(A ^ B);
         5'b11010: lres = ~A;
         5'b11011: lres = ~A | B;
         5'b11100: lres = ~B;
         5'b11101: lres = A | ~B;
         5'b11110: lres = ~A | ~B;
         5'b11111: lres = {{(WIDTH-1){1'b0}}, 1'b1};
         5'b01000, 5'b01001, 5'b01010, 5'b01100: begin end
         default:  uerr = 1'b1;
      endcase
      sum  = {1'b0, A} + {1'b0, addb} + {{WIDTH{1'b0}}, cin};
      sres = arith ? sum[WIDTH-1:0] : lres;
      sc   = arith & sum[WIDTH];
      sv   = arith & (A[WIDTH-1] == addb[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
   end

   // Completion logic. A shift performs its first step on the acceptance edge,
   // so an n-bit shift spends n-1 cycles in BUSY and finishes n cycles after
   // acceptance; n of 0 or 1 finishes directly.
   logic [WIDTH:0]   step;
   logic [WIDTH-1:0] macc;
   logic             go_done;
   logic [WIDTH-1:0] d_out;
   logic             d_c;
   logic             d_v;
   logic             d_err;

   always_comb begin
      step    = shstep((state == IDLE) ? opcode[1:0] : op_r[1:0], (state == IDLE) ? A : acc);
      macc    = acc + (rb[0] ? ra : '0);
      go_done = 1'b0;
      d_out   = sres;
      d_c     = sc;
      d_v     = sv;
      d_err   = uerr;
      if (state == IDLE && in_valid) begin
         if (in_shift) begin
            if (n == '0) begin
               go_done = 1'b1;
               d_out   = A;
               d_c     = 1'b0;
            end else if (n == SHW'(1)) begin
               go_done = 1'b1;
               d_out   = step[WIDTH-1:0];
               d_c     = step[WIDTH];
            end
         end else if (!in_mul) begin
            go_done = 1'b1;
         end
      end else if (state == BUSY && cnt == '0) begin
         go_done = 1'b1;
         d_err   = 1'b0;
         d_v     = 1'b0;
         if (busy_mul) begin
            d_out = macc;
            d_c   = 1'b0;
         end else begin
            d_out = step[WIDTH-1:0];
            d_c   = step[WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_r  <= '0;
         acc   <= '0;
         ra    <= '0;
         rb    <= '0;
         cnt   <= '0;
         Out   <= '0;
         Flag  <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r  <= opcode;
                  ra    <= A;
                  rb    <= B;
                  acc   <= in_mul ? '0 : step[WIDTH-1:0];
                  cnt   <= in_mul ? SHW'(WIDTH - 1) : n - SHW'(2);
                  state <= go_done ? DONE : BUSY;
               end
            end
            BUSY: begin
               if (busy_mul) begin
                  acc <= macc;
                  ra  <= ra << 1;
                  rb  <= rb >> 1;
               end else begin
                  acc <= step[WIDTH-1:0];
               end
               cnt <= cnt - SHW'(1);
               if (go_done) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (go_done) begin
            Out  <= d_out;
            Flag <= {d_out[WIDTH-1], d_out == '0, d_c, d_v};
            err  <= d_err;
         end
      end
   end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 The parameters SHALL be: WIDTH, default 32, operand/result width (power of two, 8..64); SHW, default $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-002 The ports SHALL be, clock and reset first:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
A  input  WIDTH  operand A
B  input  WIDTH  operand B; B[SHW-1:0] is shift amount for shifts
opcode  input  5  operation select
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
Out  output  WIDTH  result
Flag  output  4  {N,Z,C,V} of result
err  output  1  opcode was undefined
REQ-003 One clock, asynchronous active-low reset rst_n; all state SHALL be in the clk domain.

Function
REQ-004 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 A request SHALL be accepted on a clk edge with in_valid=1 and in_ready=1; A, B, opcode SHALL be captured then and later input changes ignored.
REQ-006 Single-cycle opcodes SHALL go IDLE->DONE; result valid the cycle after acceptance (latency 1).
REQ-007 Opcodes: 00000 A+B; 00001 A+B+1; 00011 A+1; 00100 A-B-1; 00101 A-B; 00110 A-1; 10000 0; 10001 A&B; 10010 ~A&B; 10011 B; 10100 A&~B; 10101 A; 10110 A^B; 10111 A|B; 11000 ~(A|B); 11001 ~(A^B); 11010 ~A; 11011 ~A|B; 11100 ~B; 11101 A|~B; 11110 ~A|~B; 11111 1.
REQ-008 Iterative opcodes: 01000 LSL, 01001 ASR, 01010 LSR by n=B[SHW-1:0], one bit per cycle in BUSY; n=0 SHALL go directly to DONE with Out=A; total latency max(n,1) cycles after acceptance.
REQ-009 Opcode 01100 MUL: shift-add unsigned, low WIDTH bits of A*B, exactly WIDTH cycles in BUSY, latency WIDTH+1.
REQ-010 Undefined opcodes (00010, 00111, 01011, 01101, 01110, 01111) SHALL complete in 1 cycle with Out=0, Flag=0100, err=1; err=0 for all defined opcodes.
REQ-011 Arithmetic SHALL be modulo 2^WIDTH; C = carry-out of WIDTH-bit add; for subtracts C=1 means no borrow; V = two's-complement overflow; logic ops and MUL C=V=0; shifts C = last bit shifted out (0 when n=0), V=0.
REQ-012 Z SHALL be 1 iff Out==0; N SHALL equal Out[WIDTH-1].
REQ-013 In DONE, Out/Flag/err SHALL stay stable until out_ready=1; DONE with out_ready=1 SHALL go to IDLE next edge; no new request accepted in the same cycle.
REQ-014 out_ready during IDLE/BUSY SHALL be ignored; in_valid during BUSY/DONE SHALL be ignored and not queued.

Reset
REQ-015 rst_n=0 SHALL immediately force IDLE, in_ready=1 after deassertion, out_valid=0, Out=0, Flag=0000, err=0, abort any BUSY operation with no result produced.
REQ-016 First request SHALL be acceptable on the first rising clk edge with rst_n=1.

Verification
REQ-017 A=1, B=2, op 00000, out_ready=1 -> out_valid 1 cycle later, Out=3, Flag=0000, err=0.
REQ-018 A=0x7FFFFFFF, B=1, op 00000 -> Out=0x80000000, Flag N=1 V=1 C=0 Z=0; A=5, B=5, op 00101 -> Out=0, Z=1, C=1.
REQ-019 A=0x80000001, B=4, op 01001 -> out_valid exactly 4 cycles after accept, Out=0xF8000000, C=0; same with op 01010 -> Out=0x08000000; B=0 -> Out=A after 1 cycle.
REQ-020 A=1234, B=5678, op 01100 -> Out=7006652 after 32 cycles, in_ready=0 throughout BUSY, in_valid pulses ignored.
REQ-021 out_ready=0 for 5 cycles in DONE -> Out/Flag held, in_ready=0; then out_ready=1 -> IDLE next edge; op 00111 -> Out=0, Flag=0100, err=1.
REQ-022 rst_n pulsed low mid-MUL (cycle 10) -> out_valid=0, Out=0 at once; after release, A=2, B=3, op 10111 -> Out=3.
